// File: rtl/hazard_ctrl_if.sv
// Hazard controller signal bundle: pipeline-stage register ids and enables in, stall/flush/forward controls out.
// The pipeline side uses the master modport and hazard_ctrl uses the slave modport.
interface hazard_ctrl_if #(
    parameter int CNT_WIDTH = 16
);
    logic [4:0]           Rs1D, Rs2D;
    logic [4:0]           Rs1E, Rs2E, RdE;
    logic [6:0]           opcodeE;
    logic [4:0]           RdM, RdW;
    logic                 RegWriteM, RegWriteW;
    logic                 PCSrcE;
    logic                 MdStartE;
    logic                 CntClr;
    logic                 StallF, StallD, StallE;
    logic                 FlushD, FlushE;
    logic [1:0]           ForwardAE, ForwardBE;
    logic                 MdDoneE;
    logic [CNT_WIDTH-1:0] StallCnt, FlushCnt;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, opcodeE, RdM, RdW,
               RegWriteM, RegWriteW, PCSrcE, MdStartE, CntClr,
        input  StallF, StallD, StallE, FlushD, FlushE,
               ForwardAE, ForwardBE, MdDoneE, StallCnt, FlushCnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, opcodeE, RdM, RdW,
               RegWriteM, RegWriteW, PCSrcE, MdStartE, CntClr,
        output StallF, StallD, StallE, FlushD, FlushE,
               ForwardAE, ForwardBE, MdDoneE, StallCnt, FlushCnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use/branch/mul-div stalls and flushes (combinational),
// registered perf counters (+1 cycle). It consumes no backpressure; its stalls are the pipeline's backpressure.
module hazard_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int MD_LATENCY = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);
    localparam logic [0:0]           S_IDLE      = 1'b0;
    localparam logic [0:0]           S_BUSY      = 1'b1;
    localparam logic [3:0]           MD_CNT_INIT = 4'(MD_LATENCY - 2);
    localparam logic [6:0]           OP_LOAD     = 7'b0000011;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

    if (DATA_WIDTH < 1 || MD_LATENCY < 2 || MD_LATENCY > 16) begin : g_bad_params
        $error("hazard_ctrl: illegal DATA_WIDTH or MD_LATENCY");
    end

    logic [0:0]           state;
    logic [3:0]           cnt;
    logic                 md_stall;
    logic                 lw_stall;
    logic                 br_flush;
    logic [CNT_WIDTH-1:0] stall_cnt;
    logic [CNT_WIDTH-1:0] flush_cnt;

    // Memory stage wins over writeback; x0 is hardwired zero and never forwards.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic       reg_write_m, input logic [4:0] rd_m,
                                           input logic       reg_write_w, input logic [4:0] rd_w);
        if (reg_write_m && rd_m != 5'd0 && rd_m == rs)
            return 2'b10;
        else if (reg_write_w && rd_w != 5'd0 && rd_w == rs)
            return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
        hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
    end

    always_comb begin
        lw_stall   = (hz.opcodeE == OP_LOAD) && (hz.RdE != 5'd0) &&
                     ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
        md_stall   = ((state == S_IDLE) && hz.MdStartE) || ((state == S_BUSY) && (cnt != 4'd0));
        hz.MdDoneE = (state == S_BUSY) && (cnt == 4'd0);
        br_flush   = !md_stall && hz.PCSrcE;
    end

    always_comb begin
        hz.StallF = 1'b0;
        hz.StallD = 1'b0;
        hz.StallE = 1'b0;
        hz.FlushD = 1'b0;
        hz.FlushE = 1'b0;
        if (md_stall) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.StallE = 1'b1;
        end else if (hz.PCSrcE) begin
            hz.FlushD = 1'b1;
            hz.FlushE = 1'b1;
        end else if (lw_stall) begin
            // Hold F/D and bubble E so the load result can reach the consumer.
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.FlushE = 1'b1;
        end
    end

    // The start cycle counts as the first stall cycle, hence the load of MD_LATENCY-2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hz.MdStartE) begin
                        state <= S_BUSY;
                        cnt   <= MD_CNT_INIT;
                    end
                end
                default: begin
                    if (cnt != 4'd0)
                        cnt <= cnt - 4'd1;
                    else
                        state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (hz.CntClr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hz.StallD && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            if (br_flush && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + CNT_WIDTH'(1);
        end
    end

    assign hz.StallCnt = stall_cnt;
    assign hz.FlushCnt = flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus a randomized run against a cycle-level model.
module tb_hazard_ctrl;
    localparam int L   = 4;
    localparam int CW  = 16;
    localparam int SAT = (1 << CW) - 1;
    localparam logic [6:0] LOAD = 7'b0000011;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    hazard_ctrl_if #(.CNT_WIDTH(CW)) hz();

    hazard_ctrl #(.DATA_WIDTH(32), .MD_LATENCY(L), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    // Reference model: m_age = cycles since the mul/div start cycle (-1 when no op in flight).
    int   m_age  = -1;
    int   m_scnt = 0;
    int   m_fcnt = 0;
    logic m_md, m_lw;
    logic [9:0] m_vec;

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input logic wm, input logic [4:0] rdm,
                                           input logic ww, input logic [4:0] rdw);
        if (wm && rdm != 0 && rdm == rs) return 2'b10;
        if (ww && rdw != 0 && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        m_md = (m_age < 0) ? hz.MdStartE : (m_age <= L - 2);
        m_lw = (hz.opcodeE == LOAD) && (hz.RdE != 0) && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
        // {StallF, StallD, StallE, FlushD, FlushE, MdDoneE, ForwardAE, ForwardBE}
        m_vec = {m_md || (!hz.PCSrcE && m_lw),
                 m_md || (!hz.PCSrcE && m_lw),
                 m_md,
                 !m_md && hz.PCSrcE,
                 !m_md && (hz.PCSrcE || m_lw),
                 m_age == L - 1,
                 ref_fwd(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW),
                 ref_fwd(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW)};
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_age  <= -1;
            m_scnt <= 0;
            m_fcnt <= 0;
        end else begin
            if (m_age < 0)           m_age <= hz.MdStartE ? 1 : -1;
            else if (m_age >= L - 1) m_age <= -1;
            else                     m_age <= m_age + 1;
            if (hz.CntClr) begin
                m_scnt <= 0;
                m_fcnt <= 0;
            end else begin
                if (m_vec[8] && m_scnt < SAT) m_scnt <= m_scnt + 1;
                if (!m_md && hz.PCSrcE && m_fcnt < SAT) m_fcnt <= m_fcnt + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0; hz.RdE = 0;
        hz.opcodeE = 7'b0110011; hz.RdM = 0; hz.RdW = 0;
        hz.RegWriteM = 0; hz.RegWriteW = 0; hz.PCSrcE = 0; hz.MdStartE = 0; hz.CntClr = 0;
    endtask

    task automatic clear_counters();
        idle_inputs();
        hz.CntClr = 1;
        tick();
        hz.CntClr = 0;
    endtask

    function automatic logic [4:0] sf_vec();
        return {hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE};
    endfunction

    task automatic test_reset();
        idle_inputs();
        hz.PCSrcE = 1; hz.CntClr = 0;
        rst_n = 0;
        repeat (3) tick();
        hz.PCSrcE = 0;
        #1;
        checks++;
        if ({sf_vec(), hz.MdDoneE, hz.ForwardAE, hz.ForwardBE} !== 10'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=0", {sf_vec(), hz.MdDoneE, hz.ForwardAE, hz.ForwardBE});
        end
        checks++;
        if (hz.StallCnt !== 16'd0 || hz.FlushCnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_counters got=%0d/%0d want=0/0", hz.StallCnt, hz.FlushCnt);
        end
        rst_n = 1;
        tick();
    endtask

    task automatic test_forwarding();
        idle_inputs();
        hz.RegWriteM = 1; hz.RdM = 5; hz.RegWriteW = 1; hz.RdW = 5; hz.Rs1E = 5; hz.Rs2E = 5;
        #1;
        checks++;
        if (hz.ForwardAE !== 2'b10 || hz.ForwardBE !== 2'b10) begin
            failures++;
            $display("FAIL fwd_mem_priority got=%b/%b want=10/10", hz.ForwardAE, hz.ForwardBE);
        end
        hz.RegWriteM = 0;
        #1;
        checks++;
        if (hz.ForwardAE !== 2'b01) begin
            failures++;
            $display("FAIL fwd_wb got=%b want=01", hz.ForwardAE);
        end
        hz.RdM = 0; hz.RdW = 0; hz.RegWriteM = 1;
        #1;
        checks++;
        if (hz.ForwardAE !== 2'b00) begin
            failures++;
            $display("FAIL fwd_none got=%b want=00", hz.ForwardAE);
        end
        hz.Rs1E = 0; hz.Rs2E = 0;
        #1;
        checks++;
        if (hz.ForwardAE !== 2'b00 || hz.ForwardBE !== 2'b00) begin
            failures++;
            $display("FAIL fwd_x0 got=%b/%b want=00/00", hz.ForwardAE, hz.ForwardBE);
        end
        hz.RdM = 6; hz.Rs2E = 6; hz.RdW = 5; hz.Rs1E = 5;
        #1;
        checks++;
        if (hz.ForwardAE !== 2'b01 || hz.ForwardBE !== 2'b10) begin
            failures++;
            $display("FAIL fwd_split got=%b/%b want=01/10", hz.ForwardAE, hz.ForwardBE);
        end
        idle_inputs();
    endtask

    task automatic test_load_use();
        clear_counters();
        hz.opcodeE = LOAD; hz.RdE = 7; hz.Rs2D = 7;
        #1;
        checks++;
        if (sf_vec() !== 5'b11001) begin
            failures++;
            $display("FAIL load_use got=%b want=11001", sf_vec());
        end
        tick();
        idle_inputs();
        hz.opcodeE = LOAD; hz.RdE = 0; hz.Rs1D = 0;
        #1;
        checks++;
        if (sf_vec() !== 5'b00000) begin
            failures++;
            $display("FAIL load_use_x0 got=%b want=00000", sf_vec());
        end
        checks++;
        if (hz.StallCnt !== 16'd1 || hz.FlushCnt !== 16'd0) begin
            failures++;
            $display("FAIL load_use_counts got=%0d/%0d want=1/0", hz.StallCnt, hz.FlushCnt);
        end
        idle_inputs();
    endtask

    task automatic test_branch_load_use();
        clear_counters();
        hz.opcodeE = LOAD; hz.RdE = 7; hz.Rs1D = 7; hz.PCSrcE = 1;
        #1;
        checks++;
        if (sf_vec() !== 5'b00011) begin
            failures++;
            $display("FAIL branch_over_lw got=%b want=00011", sf_vec());
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (hz.FlushCnt !== 16'd1 || hz.StallCnt !== 16'd0) begin
            failures++;
            $display("FAIL branch_counts got=%0d/%0d want=1/0", hz.FlushCnt, hz.StallCnt);
        end
    endtask

    task automatic test_muldiv();
        logic [4:0] want_sf [0:4] = '{5'b11100, 5'b11100, 5'b11100, 5'b00000, 5'b00000};
        logic       want_dn [0:4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        clear_counters();
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            hz.MdStartE = (c == 0 || c == 2);
            hz.PCSrcE   = (c == 1);
            #1;
            checks++;
            if (sf_vec() !== want_sf[c] || hz.MdDoneE !== want_dn[c]) begin
                failures++;
                $display("FAIL muldiv_cycle%0d got=%b/%b want=%b/%b", c, sf_vec(), hz.MdDoneE, want_sf[c], want_dn[c]);
            end
            tick();
        end
        idle_inputs();
        #1;
        checks++;
        if (hz.StallCnt !== 16'd3 || hz.FlushCnt !== 16'd0) begin
            failures++;
            $display("FAIL muldiv_counts got=%0d/%0d want=3/0", hz.StallCnt, hz.FlushCnt);
        end
    endtask

    task automatic test_reset_busy();
        int stalls  = 0;
        int done_at = -1;
        clear_counters();
        hz.MdStartE = 1;
        tick();
        hz.MdStartE = 0;
        rst_n = 0;
        #1;
        checks++;
        if (sf_vec() !== 5'b0 || hz.MdDoneE !== 1'b0 || hz.StallCnt !== 16'd0 || hz.FlushCnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_busy got=%b/%b/%0d/%0d want=0/0/0/0", sf_vec(), hz.MdDoneE, hz.StallCnt, hz.FlushCnt);
        end
        tick();
        rst_n = 1;
        tick();
        for (int c = 0; c < 6; c++) begin
            hz.MdStartE = (c == 0);
            #1;
            if (hz.StallE) stalls++;
            if (hz.MdDoneE && done_at < 0) done_at = c;
            tick();
        end
        hz.MdStartE = 0;
        checks++;
        if (stalls !== L - 1 || done_at !== L - 1) begin
            failures++;
            $display("FAIL reset_busy_restart got=%0d/%0d want=%0d/%0d", stalls, done_at, L - 1, L - 1);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 3000; i++) begin
            hz.Rs1D = 5'($urandom_range(0, 3)); hz.Rs2D = 5'($urandom_range(0, 3));
            hz.Rs1E = 5'($urandom_range(0, 3)); hz.Rs2E = 5'($urandom_range(0, 3));
            hz.RdE  = 5'($urandom_range(0, 3)); hz.RdM  = 5'($urandom_range(0, 3));
            hz.RdW  = 5'($urandom_range(0, 3));
            hz.opcodeE   = ($urandom_range(0, 1) == 0) ? LOAD : 7'($urandom);
            hz.RegWriteM = 1'($urandom); hz.RegWriteW = 1'($urandom);
            hz.PCSrcE    = ($urandom_range(0, 3) == 0);
            hz.MdStartE  = ($urandom_range(0, 5) == 0);
            hz.CntClr    = ($urandom_range(0, 99) == 0);
            #1;
            checks++;
            if ({sf_vec(), hz.MdDoneE, hz.ForwardAE, hz.ForwardBE} !== m_vec) begin
                failures++;
                if (errs++ < 10)
                    $display("FAIL random_outputs cycle=%0d got=%b want=%b", i, {sf_vec(), hz.MdDoneE, hz.ForwardAE, hz.ForwardBE}, m_vec);
            end
            checks++;
            if (hz.StallCnt !== 16'(m_scnt) || hz.FlushCnt !== 16'(m_fcnt)) begin
                failures++;
                if (errs++ < 10)
                    $display("FAIL random_counters cycle=%0d got=%0d/%0d want=%0d/%0d", i, hz.StallCnt, hz.FlushCnt, m_scnt, m_fcnt);
            end
            tick();
        end
        idle_inputs();
        repeat (L) tick();
    endtask

    task automatic test_saturation();
        clear_counters();
        hz.opcodeE = LOAD; hz.RdE = 7; hz.Rs1D = 7;
        repeat (SAT + 6) tick();
        checks++;
        if (hz.StallCnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL saturation got=%0d want=%0d", hz.StallCnt, SAT);
        end
        hz.CntClr = 1;
        tick();
        hz.CntClr = 0;
        checks++;
        if (hz.StallCnt !== 16'd0) begin
            failures++;
            $display("FAIL clear_wins got=%0d want=0", hz.StallCnt);
        end
        tick();
        checks++;
        if (hz.StallCnt !== 16'd1) begin
            failures++;
            $display("FAIL count_after_clear got=%0d want=1", hz.StallCnt);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_load_use();
        test_muldiv();
        test_reset_busy();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
